// File: rtl/dt_ridge.sv
// -----------------------------------------------------------------------------
// dt_ridge
// Ridge (medial-axis) extractor that runs after the distance-transform stage.
// It scans the IMG_W x IMG_W distance map held in the res memory. A pixel is
// marked as a ridge pixel when it is an interior, nonzero local maximum over
// its four neighbours. Ridge bits are packed 16 per word, MSB-first, into the
// skeleton memory. The block also reports the global maximum distance and the
// ridge-pixel count.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   start      begins a scan; sampled only in IDLE or DONE
//   res_rd     res memory read enable
//   res_addr   res memory address = row*IMG_W + col
//   res_di     res read data, valid one cycle after res_rd
//   sk_wr      one-cycle skeleton write strobe
//   sk_addr    skeleton word address = row*(IMG_W/16) + col/16
//   sk_do      packed ridge bits; bit (15 - col%16) belongs to column col
//   max_dist   maximum distance over the map (valid when done)
//   ridge_cnt  ridge pixel count, saturating (valid when done)
//   done       high from scan completion until the next accepted start
// -----------------------------------------------------------------------------
module dt_ridge #(
  parameter int IMG_W = 128,
  parameter int DW    = 8,
  localparam int AW   = $clog2(IMG_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              res_rd,
  output logic [2*AW-1:0]   res_addr,
  input  logic [DW-1:0]     res_di,
  output logic              sk_wr,
  output logic [2*AW-5:0]   sk_addr,
  output logic [15:0]       sk_do,
  output logic [DW-1:0]     max_dist,
  output logic [2*AW-1:0]   ridge_cnt,
  output logic              done
);

  localparam logic [2*AW-1:0] ROW_STEP = (2*AW)'(IMG_W);
  localparam logic [2*AW-1:0] ONE      = {{(2*AW-1){1'b0}}, 1'b1};
  localparam logic [2*AW-1:0] CNT_MAX  = {(2*AW){1'b1}};
  localparam logic [AW-1:0]   EDGE_HI  = {AW{1'b1}};
  localparam logic [AW-1:0]   EDGE_LO  = {AW{1'b0}};

  // Each state names the cycle in which its registered outputs are visible.
  // DAT is the cycle the centre value returns; NB0..NB3 issue N,S,W,E and the
  // value of the previously issued neighbour returns in the following state.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_CEN  = 4'd1,
    S_DAT  = 4'd2,
    S_NB0  = 4'd3,
    S_NB1  = 4'd4,
    S_NB2  = 4'd5,
    S_NB3  = 4'd6,
    S_EVAL = 4'd7,
    S_FIN  = 4'd8,
    S_DONE = 4'd9
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     row_q, row_d;
  logic [AW-1:0]     col_q, col_d;
  logic [DW-1:0]     cen_q, cen_d;
  logic              ok_q, ok_d;
  logic [15:0]       acc_q, acc_d;
  logic              res_rd_q, res_rd_d;
  logic [2*AW-1:0]   res_addr_q, res_addr_d;
  logic              sk_wr_q, sk_wr_d;
  logic [2*AW-5:0]   sk_addr_q, sk_addr_d;
  logic [15:0]       sk_do_q, sk_do_d;
  logic [DW-1:0]     max_q, max_d;
  logic [2*AW-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;

  logic [2*AW-1:0]   pix_addr_s;
  logic              interior_s;
  logic              last_s;
  logic              bit_s;
  logic [15:0]       acc_new_s;
  logic [AW-1:0]     col_nxt_s;
  logic [AW-1:0]     row_nxt_s;

  // Next-state and datapath logic for the scan FSM.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    cen_d      = cen_q;
    ok_d       = ok_q;
    acc_d      = acc_q;
    res_rd_d   = 1'b0;
    res_addr_d = res_addr_q;
    sk_wr_d    = 1'b0;
    sk_addr_d  = sk_addr_q;
    sk_do_d    = sk_do_q;
    max_d      = max_q;
    cnt_d      = cnt_q;
    done_d     = done_q;

    pix_addr_s = {row_q, col_q};
    interior_s = (row_q != EDGE_LO) && (row_q != EDGE_HI) &&
                 (col_q != EDGE_LO) && (col_q != EDGE_HI);
    last_s     = (row_q == EDGE_HI) && (col_q == EDGE_HI);
    // ok_q is cleared on the zero/border path, so the stale res_di seen in
    // EVAL on that path can never produce a ridge bit.
    bit_s      = ok_q && (res_di <= cen_q);
    acc_new_s  = bit_s ? (acc_q | (16'h8000 >> col_q[3:0])) : acc_q;
    col_nxt_s  = col_q + {{(AW-1){1'b0}}, 1'b1};
    row_nxt_s  = (col_q == EDGE_HI) ? (row_q + {{(AW-1){1'b0}}, 1'b1}) : row_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          row_d      = EDGE_LO;
          col_d      = EDGE_LO;
          max_d      = {DW{1'b0}};
          cnt_d      = {(2*AW){1'b0}};
          done_d     = 1'b0;
          acc_d      = 16'h0000;
          ok_d       = 1'b0;
          res_rd_d   = 1'b1;
          res_addr_d = {(2*AW){1'b0}};
          state_d    = S_CEN;
        end else begin
          state_d    = state_q;
        end
      end
      S_CEN: begin
        state_d = S_DAT;
      end
      S_DAT: begin
        cen_d = res_di;
        if (res_di > max_q) begin
          max_d = res_di;
        end else begin
          max_d = max_q;
        end
        if (interior_s && (res_di != {DW{1'b0}})) begin
          ok_d       = 1'b1;
          res_rd_d   = 1'b1;
          res_addr_d = pix_addr_s - ROW_STEP;
          state_d    = S_NB0;
        end else begin
          ok_d       = 1'b0;
          state_d    = S_EVAL;
        end
      end
      S_NB0: begin
        res_rd_d   = 1'b1;
        res_addr_d = pix_addr_s + ROW_STEP;
        state_d    = S_NB1;
      end
      S_NB1, S_NB2, S_NB3: begin
        if (res_di > cen_q) begin
          ok_d = 1'b0;
        end else begin
          ok_d = ok_q;
        end
        if (state_q == S_NB1) begin
          res_rd_d   = 1'b1;
          res_addr_d = pix_addr_s - ONE;
          state_d    = S_NB2;
        end else if (state_q == S_NB2) begin
          res_rd_d   = 1'b1;
          res_addr_d = pix_addr_s + ONE;
          state_d    = S_NB3;
        end else begin
          state_d    = S_EVAL;
        end
      end
      S_EVAL: begin
        if (bit_s && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + ONE;
        end else begin
          cnt_d = cnt_q;
        end
        if (col_q[3:0] == 4'hF) begin
          sk_wr_d   = 1'b1;
          sk_addr_d = {row_q, col_q[AW-1:4]};
          sk_do_d   = acc_new_s;
          acc_d     = 16'h0000;
        end else begin
          acc_d     = acc_new_s;
        end
        if (last_s) begin
          state_d    = S_FIN;
        end else begin
          col_d      = col_nxt_s;
          row_d      = row_nxt_s;
          res_rd_d   = 1'b1;
          res_addr_d = {row_nxt_s, col_nxt_s};
          state_d    = S_CEN;
        end
      end
      S_FIN: begin
        // Final word is being written this cycle; report completion next.
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      row_q      <= {AW{1'b0}};
      col_q      <= {AW{1'b0}};
      cen_q      <= {DW{1'b0}};
      ok_q       <= 1'b0;
      acc_q      <= 16'h0000;
      res_rd_q   <= 1'b0;
      res_addr_q <= {(2*AW){1'b0}};
      sk_wr_q    <= 1'b0;
      sk_addr_q  <= {(2*AW-4){1'b0}};
      sk_do_q    <= 16'h0000;
      max_q      <= {DW{1'b0}};
      cnt_q      <= {(2*AW){1'b0}};
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      cen_q      <= cen_d;
      ok_q       <= ok_d;
      acc_q      <= acc_d;
      res_rd_q   <= res_rd_d;
      res_addr_q <= res_addr_d;
      sk_wr_q    <= sk_wr_d;
      sk_addr_q  <= sk_addr_d;
      sk_do_q    <= sk_do_d;
      max_q      <= max_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

  assign res_rd    = res_rd_q;
  assign res_addr  = res_addr_q;
  assign sk_wr     = sk_wr_q;
  assign sk_addr   = sk_addr_q;
  assign sk_do     = sk_do_q;
  assign max_dist  = max_q;
  assign ridge_cnt = cnt_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dt_ridge.sv
// -----------------------------------------------------------------------------
// tb_dt_ridge
// Self-checking bench for dt_ridge on a 32x32 map (keeps every scan short).
// A reference model derives the expected skeleton words from the map; they are
// queued before each scan and popped as the DUT writes them.
// -----------------------------------------------------------------------------
module tb_dt_ridge;

  localparam int W  = 32;
  localparam int NP = W * W;
  localparam int NW = NP / 16;

  typedef struct {
    logic [5:0]  a;
    logic [15:0] d;
  } wr_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        res_rd;
  logic [9:0]  res_addr;
  logic [7:0]  res_di;
  logic        sk_wr;
  logic [5:0]  sk_addr;
  logic [15:0] sk_do;
  logic [7:0]  max_dist;
  logic [9:0]  ridge_cnt;
  logic        done;

  logic [7:0]  mem [0:NP-1];
  logic [15:0] got_word [0:NW-1];
  wr_t         exp_q [$];
  int          checks;
  int          errors;
  int          wr_cnt;
  logic [7:0]  model_max;
  int          model_cnt;

  dt_ridge #(.IMG_W(W), .DW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .res_rd    (res_rd),
    .res_addr  (res_addr),
    .res_di    (res_di),
    .sk_wr     (sk_wr),
    .sk_addr   (sk_addr),
    .sk_do     (sk_do),
    .max_dist  (max_dist),
    .ridge_cnt (ridge_cnt),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read res memory model.
  always @(posedge clk) begin
    if (res_rd) res_di <= mem[res_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Skeleton write monitor / scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b1 && sk_wr === 1'b1) begin
      wr_t e;
      wr_cnt++;
      got_word[sk_addr] = sk_do;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(sk_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sk_addr", 32'(sk_addr), 32'(e.a));
        chk("sk_do", 32'(sk_do), 32'(e.d));
      end
    end
  end

  function automatic logic [7:0] px(input int r, input int c);
    return mem[r * W + c];
  endfunction

  function automatic bit is_ridge(input int r, input int c);
    logic [7:0] d;
    if (r < 1 || r > W - 2 || c < 1 || c > W - 2) return 1'b0;
    d = px(r, c);
    if (d == 8'd0) return 1'b0;
    return (d >= px(r - 1, c)) && (d >= px(r + 1, c)) &&
           (d >= px(r, c - 1)) && (d >= px(r, c + 1));
  endfunction

  task automatic build_expected();
    wr_t e;
    exp_q.delete();
    model_max = 8'd0;
    model_cnt = 0;
    for (int r = 0; r < W; r++) begin
      for (int w = 0; w < W / 16; w++) begin
        e.a = 6'(r * (W / 16) + w);
        e.d = 16'h0000;
        for (int b = 0; b < 16; b++) begin
          if (px(r, w * 16 + b) > model_max) model_max = px(r, w * 16 + b);
          if (is_ridge(r, w * 16 + b)) begin
            e.d[15 - b] = 1'b1;
            model_cnt++;
          end
        end
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic clear_map();
    for (int i = 0; i < NP; i++) mem[i] = 8'd0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_low_after_start", 32'(done), 32'd0);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20000 && done !== 1'b1; i++) @(negedge clk);
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic finish_scan(input string tag, input logic [7:0] emax, input int ecnt);
    wait_done({tag, "_done"});
    chk({tag, "_writes"}, 32'(wr_cnt), 32'(NW));
    chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_max"}, 32'(max_dist), 32'(emax));
    chk({tag, "_cnt"}, 32'(ridge_cnt), 32'(ecnt));
  endtask

  task automatic run_scan(input string tag, input logic [7:0] emax, input int ecnt);
    build_expected();
    wr_cnt = 0;
    pulse_start();
    finish_scan(tag, emax, ecnt);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_res_rd"}, 32'(res_rd), 32'd0);
    chk({tag, "_sk_wr"}, 32'(sk_wr), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_res_addr"}, 32'(res_addr), 32'd0);
    chk({tag, "_sk_addr"}, 32'(sk_addr), 32'd0);
    chk({tag, "_sk_do"}, 32'(sk_do), 32'd0);
    chk({tag, "_max"}, 32'(max_dist), 32'd0);
    chk({tag, "_cnt"}, 32'(ridge_cnt), 32'd0);
  endtask

  task automatic load_block();
    clear_map();
    for (int r = 10; r <= 12; r++)
      for (int c = 20; c <= 22; c++)
        mem[r * W + c] = 8'd1;
    mem[11 * W + 21] = 8'd2;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    wr_cnt = 0;
    start  = 1'b0;
    reset  = 1'b0;
    res_di = 8'd0;
    clear_map();
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // All-zero map.
    run_scan("zero", 8'd0, 0);

    // Single d=1 at (5,5): word 10, column bit 5 -> 0x0400.
    clear_map();
    mem[5 * W + 5] = 8'd1;
    run_scan("single", 8'd1, 1);
    chk("single_word10", 32'(got_word[10]), 32'h0400);
    chk("single_word11", 32'(got_word[11]), 32'h0000);

    // 3x3 block with peak 2 in the middle: corners and centre are ridge.
    load_block();
    run_scan("block", 8'd2, 5);
    chk("block_word21", 32'(got_word[21]), 32'h0A00);
    chk("block_word23", 32'(got_word[23]), 32'h0400);
    chk("block_word25", 32'(got_word[25]), 32'h0A00);

    // Border values count toward max but never become ridge.
    clear_map();
    mem[0 * W + 3]        = 8'd9;
    mem[(W - 1) * W + W - 1] = 8'd9;
    run_scan("border", 8'd9, 0);
    chk("border_word0", 32'(got_word[0]), 32'h0000);
    chk("border_word_last", 32'(got_word[NW - 1]), 32'h0000);

    // Random small-valued map exercises plateaus and neighbour rejection.
    for (int i = 0; i < NP; i++) mem[i] = 8'($urandom_range(0, 3));
    build_expected();
    wr_cnt = 0;
    pulse_start();
    finish_scan("random", model_max, model_cnt);

    // Start during a scan is ignored; start in DONE restarts cleanly.
    load_block();
    build_expected();
    wr_cnt = 0;
    pulse_start();
    repeat (300) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_scan("midstart", 8'd2, 5);
    run_scan("restart", 8'd2, 5);
    chk("restart_word23", 32'(got_word[23]), 32'h0400);

    // Asynchronous reset in mid-scan, then a fresh scan.
    clear_map();
    mem[5 * W + 5] = 8'd7;
    build_expected();
    wr_cnt = 0;
    pulse_start();
    repeat (1500) @(negedge clk);
    chk("pre_reset_busy", 32'(done), 32'd0);
    reset = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    wr_cnt = 0;
    repeat (50) @(negedge clk);
    chk("no_write_after_reset", 32'(wr_cnt), 32'd0);
    chk("idle_after_reset_done", 32'(done), 32'd0);
    run_scan("after_reset", 8'd7, 1);
    chk("after_reset_word10", 32'(got_word[10]), 32'h0400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
